cpu_controller: RTL and testbench

- Instruction-sequencing controller for the 16-bit RISC core.
- Fetches instructions from the 256-word unified memory, holds PC and IR, and decodes fields.
- Drives every control input of the register-file/ALU datapath: register selects, load strobes, mux selects, ALUop, shift and sign-extended immediates.
- Is the producer side of the datapath control interface and the initiator on the memory bus.

---
 rtl/cpu_controller_pkg.sv | 64 ++++++
 rtl/cpu_controller_decoder.sv | 26 ++
 rtl/cpu_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_cpu_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_controller_pkg.sv
// Shared constants for the RISC instruction-sequencing controller: FSM states,
// opcode/op encodings, memory commands, ALU ops and write-back selects.
package cpu_pkg;

   localparam int PC_W_DEF = 8;
   localparam int IR_W_DEF = 16;

   typedef logic [4:0] state_t;

   localparam state_t S_IF1       = 5'd0;
   localparam state_t S_IF2       = 5'd1;
   localparam state_t S_UPDATE_PC = 5'd2;
   localparam state_t S_DECODE    = 5'd3;
   localparam state_t S_WRITE_IMM = 5'd4;
   localparam state_t S_GET_A     = 5'd5;
   localparam state_t S_GET_B     = 5'd6;
   localparam state_t S_ALU       = 5'd7;
   localparam state_t S_WRITE_RD  = 5'd8;
   localparam state_t S_ADDR      = 5'd9;
   localparam state_t S_LATCH     = 5'd10;
   localparam state_t S_LDR_MEM   = 5'd11;
   localparam state_t S_LDR_WB    = 5'd12;
   localparam state_t S_STR_GETB  = 5'd13;
   localparam state_t S_STR_DATA  = 5'd14;
   localparam state_t S_STR_MEM   = 5'd15;
   localparam state_t S_HALT      = 5'd16;

   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM   = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   function automatic logic [15:0] sext5(input logic [4:0] v);
      return {{11{v[4]}}, v};
   endfunction

   function automatic logic [15:0] sext8(input logic [7:0] v);
      return {{8{v[7]}}, v};
   endfunction

endpackage

// File: rtl/cpu_controller_decoder.sv
// Combinational field extraction and immediate sign extension for the
// instruction register.
module instruction_decoder
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  opcode,
   output logic [1:0]  op,
   output logic [2:0]  rn,
   output logic [2:0]  rd,
   output logic [2:0]  rm,
   output logic [1:0]  sh,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8
);

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];
   assign sximm5 = sext5(ir[4:0]);
   assign sximm8 = sext8(ir[7:0]);

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit RISC core; owns PC,
// IR and the latched memory address and drives all datapath/memory controls.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int PC_W = PC_W_DEF,
   parameter int IR_W = IR_W_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [IR_W-1:0] read_data,
   input  logic [IR_W-1:0] datapath_out,
   output logic [1:0]      mem_cmd,
   output logic [PC_W-1:0] mem_addr,
   output logic [2:0]      readnum,
   output logic [2:0]      writenum,
   output logic            write,
   output logic [1:0]      vsel,
   output logic            loada,
   output logic            loadb,
   output logic            asel,
   output logic            bsel,
   output logic [1:0]      shift,
   output logic [1:0]      ALUop,
   output logic            loadc,
   output logic            loads,
   output logic [IR_W-1:0] sximm8,
   output logic [IR_W-1:0] sximm5,
   output logic [PC_W-1:0] PC,
   output logic            halt
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IR_W-1:0] ir_q, ir_d;
   logic [PC_W-1:0] addr_q, addr_d;

   logic [2:0] opcode_s, rn_s, rd_s, rm_s;
   logic [1:0] op_s, sh_s;
   logic       is_cmp_s, is_mov_s;
   logic       write_s, loada_s, loadb_s, loadc_s, loads_s;
   logic [1:0] mem_cmd_s;
   logic       dp_unused_s;

   instruction_decoder u_dec (
      .ir     (ir_q),
      .opcode (opcode_s),
      .op     (op_s),
      .rn     (rn_s),
      .rd     (rd_s),
      .rm     (rm_s),
      .sh     (sh_s),
      .sximm5 (sximm5),
      .sximm8 (sximm8)
   );

   // Only the low address bits of the effective address reach the memory.
   assign dp_unused_s = ^datapath_out[IR_W-1:PC_W];

   assign is_cmp_s = (opcode_s == OPC_ALU) && (op_s == OP_CMP);
   assign is_mov_s = (opcode_s == OPC_MOV);

   // Next-state and PC/IR/address-latch update logic.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      addr_d  = addr_q;
      case (state_q)
         S_IF1:       state_d = S_IF2;
         S_IF2: begin
            ir_d    = read_data;
            state_d = S_UPDATE_PC;
         end
         S_UPDATE_PC: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode_s)
               OPC_MOV: begin
                  if (op_s == OP_MOV_IMM)      state_d = S_WRITE_IMM;
                  else if (op_s == OP_MOV_REG) state_d = S_GET_B;
                  else                         state_d = S_IF1;
               end
               OPC_ALU: begin
                  if (op_s == OP_MVN) state_d = S_GET_B;
                  else                state_d = S_GET_A;
               end
               OPC_LDR, OPC_STR: begin
                  if (op_s == OP_MEM) state_d = S_GET_A;
                  else                state_d = S_IF1;
               end
               OPC_HALT: state_d = S_HALT;
               default:  state_d = S_IF1;
            endcase
         end
         S_WRITE_IMM: state_d = S_IF1;
         S_GET_A: begin
            if (opcode_s == OPC_ALU) state_d = S_GET_B;
            else                     state_d = S_ADDR;
         end
         S_GET_B:     state_d = S_ALU;
         S_ALU: begin
            if (is_cmp_s) state_d = S_IF1;
            else          state_d = S_WRITE_RD;
         end
         S_WRITE_RD:  state_d = S_IF1;
         S_ADDR:      state_d = S_LATCH;
         S_LATCH: begin
            addr_d = datapath_out[PC_W-1:0];
            if (opcode_s == OPC_STR) state_d = S_STR_GETB;
            else                     state_d = S_LDR_MEM;
         end
         S_LDR_MEM:   state_d = S_LDR_WB;
         S_LDR_WB:    state_d = S_IF1;
         S_STR_GETB:  state_d = S_STR_DATA;
         S_STR_DATA:  state_d = S_STR_MEM;
         S_STR_MEM:   state_d = S_IF1;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_IF1;
      endcase
   end

   // State, PC, IR and address-latch registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IF1;
         pc_q    <= '0;
         ir_q    <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
      end
   end

   // Moore control decode from state and IR fields.
   always_comb begin
      mem_cmd_s = MEM_NONE;
      mem_addr  = pc_q;
      readnum   = 3'd0;
      writenum  = 3'd0;
      write_s   = 1'b0;
      vsel      = VSEL_C;
      loada_s   = 1'b0;
      loadb_s   = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      shift     = 2'b00;
      ALUop     = ALU_ADD;
      loadc_s   = 1'b0;
      loads_s   = 1'b0;
      halt      = 1'b0;
      case (state_q)
         S_IF1, S_IF2: mem_cmd_s = MEM_READ;
         S_WRITE_IMM: begin
            vsel     = VSEL_IMM;
            writenum = rn_s;
            write_s  = 1'b1;
         end
         S_GET_A: begin
            readnum = rn_s;
            loada_s = 1'b1;
         end
         S_GET_B: begin
            readnum = rm_s;
            loadb_s = 1'b1;
         end
         S_ALU: begin
            shift   = sh_s;
            asel    = is_mov_s;
            ALUop   = is_mov_s ? ALU_ADD : op_s;
            loadc_s = !is_cmp_s;
            loads_s = is_cmp_s;
         end
         S_WRITE_RD: begin
            vsel     = VSEL_C;
            writenum = rd_s;
            write_s  = 1'b1;
         end
         S_ADDR: begin
            bsel    = 1'b1;
            ALUop   = ALU_ADD;
            loadc_s = 1'b1;
         end
         S_LDR_MEM: begin
            mem_addr  = addr_q;
            mem_cmd_s = MEM_READ;
         end
         S_LDR_WB: begin
            mem_addr  = addr_q;
            mem_cmd_s = MEM_READ;
            vsel      = VSEL_MDATA;
            writenum  = rd_s;
            write_s   = 1'b1;
         end
         S_STR_GETB: begin
            readnum = rd_s;
            loadb_s = 1'b1;
         end
         S_STR_DATA: begin
            asel    = 1'b1;
            ALUop   = ALU_ADD;
            loadc_s = 1'b1;
         end
         S_STR_MEM: begin
            mem_addr  = addr_q;
            mem_cmd_s = MEM_WRITE;
         end
         S_HALT:  halt = 1'b1;
         default: halt = 1'b0;
      endcase
   end

   // Reset suppresses every side effect in the same cycle it is asserted.
   assign write   = write_s & reset_n;
   assign loada   = loada_s & reset_n;
   assign loadb   = loadb_s & reset_n;
   assign loadc   = loadc_s & reset_n;
   assign loads   = loads_s & reset_n;
   assign mem_cmd = reset_n ? mem_cmd_s : MEM_NONE;
   assign PC      = pc_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected control events are queued by the
// stimulus and matched by a monitor whenever the controller issues a strobe.
module tb_cpu_controller;

   logic        clk;
   logic        reset_n;
   logic [15:0] read_data;
   logic [15:0] datapath_out;
   logic [1:0]  mem_cmd;
   logic [7:0]  mem_addr;
   logic [2:0]  readnum, writenum;
   logic        write, loada, loadb, asel, bsel, loadc, loads, halt;
   logic [1:0]  vsel, shift, ALUop;
   logic [15:0] sximm8, sximm5;
   logic [7:0]  PC;

   cpu_controller dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .read_data    (read_data),
      .datapath_out (datapath_out),
      .mem_cmd      (mem_cmd),
      .mem_addr     (mem_addr),
      .readnum      (readnum),
      .writenum     (writenum),
      .write        (write),
      .vsel         (vsel),
      .loada        (loada),
      .loadb        (loadb),
      .asel         (asel),
      .bsel         (bsel),
      .shift        (shift),
      .ALUop        (ALUop),
      .loadc        (loadc),
      .loads        (loads),
      .sximm8       (sximm8),
      .sximm5       (sximm5),
      .PC           (PC),
      .halt         (halt)
   );

   typedef struct {
      string       name;
      int          cyc;
      logic [7:0]  pc;
      logic [28:0] v;
      logic [28:0] m;
      bit          use_sx;
      logic [15:0] s8;
      logic [15:0] s5;
   } ev_t;

   ev_t         sb[$];
   logic [15:0] mem [0:255];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          t0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory model: data valid the cycle after the address.
   always @(posedge clk) read_data <= mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [28:0] pk(input int w, la, lb, lc, ls, mc, rn, wn, vs, as, bs, sh, op, ad);
      return {w[0], la[0], lb[0], lc[0], ls[0], mc[1:0], rn[2:0], wn[2:0], vs[1:0],
              as[0], bs[0], sh[1:0], op[1:0], ad[7:0]};
   endfunction

   task automatic push(input string name, input int c, input int pc, input logic [28:0] v,
                       input int crn, input int cwn, input int cop,
                       input int usx, input int s8, input int s5);
      ev_t e;
      e.name   = name;
      e.cyc    = c;
      e.pc     = pc[7:0];
      e.v      = v;
      e.m      = pk(1, 1, 1, 1, 1, 3, (crn != 0) ? 7 : 0, (cwn != 0) ? 7 : 0,
                    3, 1, 1, 3, (cop != 0) ? 3 : 0, 255);
      e.use_sx = (usx != 0);
      e.s8     = s8[15:0];
      e.s5     = s5[15:0];
      sb.push_back(e);
   endtask

   // Expected strobe events of the test program, relative to its first IF1.
   task automatic push_prog(input int t, input int full);
      push("mov_imm",  t+4,  1, pk(1,0,0,0,0,0,0,0,2,0,0,0,0,1),      0,1,0, 1,16'hFFFD,16'hFFFD);
      push("add_geta", t+9,  2, pk(0,1,0,0,0,0,1,0,0,0,0,0,0,2),      1,0,0, 0,0,0);
      push("add_getb", t+10, 2, pk(0,0,1,0,0,0,0,0,0,0,0,0,0,2),      1,0,0, 0,0,0);
      push("add_alu",  t+11, 2, pk(0,0,0,1,0,0,0,0,0,0,0,1,0,2),      0,0,1, 0,0,0);
      push("add_wr",   t+12, 2, pk(1,0,0,0,0,0,0,2,0,0,0,0,0,2),      0,1,0, 0,0,0);
      push("cmp_geta", t+17, 3, pk(0,1,0,0,0,0,1,0,0,0,0,0,0,3),      1,0,0, 0,0,0);
      push("cmp_getb", t+18, 3, pk(0,0,1,0,0,0,0,0,0,0,0,0,0,3),      1,0,0, 0,0,0);
      push("cmp_alu",  t+19, 3, pk(0,0,0,0,1,0,0,0,0,0,0,0,1,3),      0,0,1, 0,0,0);
      push("str_geta", t+24, 4, pk(0,1,0,0,0,0,1,0,0,0,0,0,0,4),      1,0,0, 0,0,0);
      push("str_addr", t+25, 4, pk(0,0,0,1,0,0,0,0,0,0,1,0,0,4),      0,0,1, 1,16'h0062,16'h0002);
      push("str_getb", t+27, 4, pk(0,0,1,0,0,0,3,0,0,0,0,0,0,4),      1,0,0, 0,0,0);
      push("str_data", t+28, 4, pk(0,0,0,1,0,0,0,0,0,1,0,0,0,4),      0,0,1, 0,0,0);
      if (full != 0) begin
         push("str_mem",   t+29, 4, pk(0,0,0,0,0,2,0,0,0,0,0,0,0,8'h25), 0,0,0, 0,0,0);
         push("ldr_geta",  t+34, 5, pk(0,1,0,0,0,0,1,0,0,0,0,0,0,5),     1,0,0, 0,0,0);
         push("ldr_addr",  t+35, 5, pk(0,0,0,1,0,0,0,0,0,0,1,0,0,5),     0,0,1, 0,0,0);
         push("ldr_wb",    t+38, 5, pk(1,0,0,0,0,1,0,3,3,0,0,0,0,8'h25), 0,1,0, 0,0,0);
         push("mvn_getb",  t+43, 6, pk(0,0,1,0,0,0,5,0,0,0,0,0,0,6),     1,0,0, 0,0,0);
         push("mvn_alu",   t+44, 6, pk(0,0,0,1,0,0,0,0,0,0,0,0,3,6),     0,0,1, 0,0,0);
         push("mvn_wr",    t+45, 6, pk(1,0,0,0,0,0,0,4,0,0,0,0,0,6),     0,1,0, 0,0,0);
         push("movr_getb", t+54, 8, pk(0,0,1,0,0,0,7,0,0,0,0,0,0,8),     1,0,0, 0,0,0);
         push("movr_alu",  t+55, 8, pk(0,0,0,1,0,0,0,0,0,1,0,2,0,8),     0,0,1, 0,0,0);
         push("movr_wr",   t+56, 8, pk(1,0,0,0,0,0,0,6,0,0,0,0,0,8),     0,1,0, 0,0,0);
      end
   endtask

   // Monitor: every strobe-bearing cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      logic [28:0] obs;
      ev_t         e;
      if (reset_n && (write || loada || loadb || loadc || loads || mem_cmd == 2'b10)) begin
         obs = {write, loada, loadb, loadc, loads, mem_cmd, readnum, writenum, vsel,
                asel, bsel, shift, ALUop, mem_addr};
         if (sb.size() == 0) begin
            check("unexpected_event", {3'b000, obs}, 32'h0);
         end else begin
            e = sb.pop_front();
            check({e.name, "_cyc"}, cyc, e.cyc);
            check({e.name, "_sig"}, {3'b000, obs & e.m}, {3'b000, e.v & e.m});
            check({e.name, "_pc"}, 32'(PC), 32'(e.pc));
            if (e.use_sx) begin
               check({e.name, "_sximm8"}, 32'(sximm8), 32'(e.s8));
               check({e.name, "_sximm5"}, 32'(sximm5), 32'(e.s5));
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n      = 1'b0;
      datapath_out = 16'h0025;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'hD0FD;  // MOV R0,#-3
      mem[1] = 16'hA148;  // ADD R2,R1,R0,LSL#1
      mem[2] = 16'hA900;  // CMP R1,R0
      mem[3] = 16'h8162;  // STR R3,[R1,#2]
      mem[4] = 16'h6162;  // LDR R3,[R1,#2]
      mem[5] = 16'hB885;  // MVN R4,R5
      mem[6] = 16'h0000;  // NOP
      mem[7] = 16'hC0D7;  // MOV R6,R7,LSR#1
      mem[8] = 16'hE000;  // HALT

      wait_cyc(3);
      @(negedge clk);
      check("rst_mem_cmd", 32'(mem_cmd), 32'h0);
      check("rst_strobes", {27'd0, write, loada, loadb, loadc, loads}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      t0 = cyc;
      push_prog(t0, 1);
      @(negedge clk);
      check("if1_mem_addr", 32'(mem_addr), 32'h0);
      check("if1_mem_cmd", 32'(mem_cmd), 32'h1);
      check("if1_pc", 32'(PC), 32'h0);
      wait_cyc(70);
      check("prog_halt", 32'(halt), 32'h1);
      check("prog_halt_pc", 32'(PC), 32'h9);
      check("prog_halt_mem_cmd", 32'(mem_cmd), 32'h0);
      check("prog_sb_empty", 32'(sb.size()), 32'h0);

      // Rerun and abort with reset in the middle of STR_MEM.
      reset_n = 1'b0;
      wait_cyc(2);
      reset_n = 1'b1;
      t0 = cyc;
      push_prog(t0, 0);
      wait_cyc(29);
      check("str_mem_pre_reset", 32'(mem_cmd), 32'h2);
      reset_n = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[255] = 16'hE000;
      @(negedge clk);
      check("abort_mem_cmd_0", 32'(mem_cmd), 32'h0);
      check("abort_strobes_0", {27'd0, write, loada, loadb, loadc, loads}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_mem_cmd_1", 32'(mem_cmd), 32'h0);
      check("abort_strobes_1", {27'd0, write, loada, loadb, loadc, loads}, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      t0 = cyc;
      @(negedge clk);
      check("post_rst_mem_addr", 32'(mem_addr), 32'h0);
      check("post_rst_mem_cmd", 32'(mem_cmd), 32'h1);
      check("post_rst_pc", 32'(PC), 32'h0);
      check("post_rst_strobes", {27'd0, write, loada, loadb, loadc, loads}, 32'h0);
      check("abort_sb_empty", 32'(sb.size()), 32'h0);

      // NOP sled up to HALT at 0xFF: PC wraps, then HALT must be absorbing.
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (halt) break;
      end
      check("wrap_halt_reached", 32'(halt), 32'h1);
      check("wrap_halt_latency", cyc, t0 + 1024);
      check("wrap_pc", 32'(PC), 32'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_hold", {22'd0, halt, mem_cmd, 1'b0, PC}, {22'd0, 1'b1, 2'b00, 1'b0, 8'h00});
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("resume_halt", 32'(halt), 32'h0);
      check("resume_mem_addr", 32'(mem_addr), 32'h0);
      check("resume_mem_cmd", 32'(mem_cmd), 32'h1);
      wait_cyc(3);
      check("resume_pc", 32'(PC), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
